// File: rtl/scale_window_gen.sv
// Scaled-window decoder for the image generator: maps HDMI cx/cy onto source pixel/line indices
// and sub-pixel phases, locks HDMI timing to the source frame, and paces next-line fetches.
module scale_window_gen #(
  parameter int unsigned SRC_W       = 240,
  parameter int unsigned SRC_H       = 160,
  parameter int unsigned SCALE       = 4,
  parameter int unsigned X_START     = 160,
  parameter int unsigned Y_START     = 40,
  parameter int unsigned CX_W        = 11,
  parameter int unsigned CY_W        = 10,
  parameter int unsigned PHASE_DELAY = 2,
  parameter int unsigned REQ_LEAD    = 8,
  parameter int unsigned SYNC_LINES  = 2,
  localparam int unsigned SX_W = $clog2(SRC_W),
  localparam int unsigned SY_W = $clog2(SRC_H),
  localparam int unsigned PH_W = (SCALE > 1) ? $clog2(SCALE) : 1
) (
  input  logic            pxlClk,
  input  logic            rstN,
  input  logic [CX_W-1:0] cx,
  input  logic [CY_W-1:0] cy,
  input  logic [CX_W-1:0] frameWidth,
  input  logic [CY_W-1:0] frameHeight,
  input  logic            newFrameIn,
  input  logic            sameLine,
  input  logic            lineAck,
  output logic            lineReq,
  output logic            setStart,
  output logic [CX_W-1:0] setStartX,
  output logic [CY_W-1:0] setStartY,
  output logic            drawWin,
  output logic [SX_W-1:0] srcX,
  output logic [SY_W-1:0] srcY,
  output logic [PH_W-1:0] phaseX,
  output logic [PH_W-1:0] phaseY,
  output logic [PH_W-1:0] phaseXDel,
  output logic            gridAct,
  output logic [7:0]      lineMissCnt
);

  localparam int unsigned      X_END   = X_START + SRC_W * SCALE;
  localparam int unsigned      Y_END   = Y_START + SRC_H * SCALE;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(SCALE - 1);
  localparam logic [SY_W-1:0]  SY_LAST = SY_W'(SRC_H - 1);
  localparam logic [CY_W-1:0]  Y_FIRST = CY_W'(Y_START);
  localparam logic [CY_W-1:0]  SYNC_Y  = CY_W'(Y_START - SYNC_LINES);

  typedef enum logic [1:0] {LK_IDLE, LK_LOCKING, LK_LOCKED} lock_e;
  typedef enum logic       {REQ_IDLE, REQ_WAIT} req_e;

  lock_e           lock_q, lock_d;
  req_e            req_q, req_d;
  logic            draw_q, draw_d;
  logic [SX_W-1:0] src_x_q, src_x_d;
  logic [SY_W-1:0] src_y_q, src_y_d;
  logic [PH_W-1:0] ph_x_q, ph_x_d;
  logic [PH_W-1:0] ph_y_q, ph_y_d;
  logic            grid_q, grid_d;
  logic            line_req_q, line_req_d;
  logic            set_start_q, set_start_d;
  logic [CY_W-1:0] set_start_y_q, set_start_y_d;
  logic [7:0]      miss_q, miss_d;
  logic            nf_q;
  logic [CY_W-1:0] cy_q;

  logic win_c, line_end_c, req_pt_c, nf_rise_c, in_rows_c;

  assign win_c      = (32'(cx) >= X_START) && (32'(cx) < X_END) &&
                      (32'(cy) >= Y_START) && (32'(cy) < Y_END);
  assign line_end_c = (cx == frameWidth - CX_W'(1));
  assign req_pt_c   = (cx == frameWidth - CX_W'(REQ_LEAD));
  assign nf_rise_c  = newFrameIn & ~nf_q;
  assign in_rows_c  = (cy >= Y_FIRST);

  always_comb begin
    lock_d        = lock_q;
    req_d         = req_q;
    draw_d        = win_c;
    src_x_d       = '0;
    ph_x_d        = '0;
    src_y_d       = src_y_q;
    ph_y_d        = ph_y_q;
    miss_d        = miss_q;
    set_start_y_d = set_start_y_q;

    // Horizontal phase restarts on the first window pixel of every row
    if (win_c && draw_q) begin
      if (ph_x_q == PH_LAST) begin
        src_x_d = src_x_q + SX_W'(1);
      end else begin
        ph_x_d  = ph_x_q + PH_W'(1);
        src_x_d = src_x_q;
      end
    end

    if (line_end_c) begin
      if ((cy == frameHeight - CY_W'(1)) || (lock_q == LK_LOCKING)) begin
        ph_y_d  = '0;
        src_y_d = '0;
      end else if (in_rows_c) begin
        if (ph_y_q == PH_LAST) begin
          ph_y_d = '0;
          if (src_y_q != SY_LAST) src_y_d = src_y_q + SY_W'(1);
        end else begin
          ph_y_d = ph_y_q + PH_W'(1);
        end
      end
    end

    grid_d = (ph_x_d == '0) || (ph_y_d == '0);

    // A fresh frame edge always restarts locking; lock completes once HDMI cy reloads
    case (lock_q)
      LK_IDLE:    if (nf_rise_c) lock_d = LK_LOCKING;
      LK_LOCKING: if (!nf_rise_c && (cy != cy_q)) lock_d = LK_LOCKED;
      LK_LOCKED:  if (nf_rise_c) lock_d = LK_LOCKING;
      default:    lock_d = LK_IDLE;
    endcase
    set_start_d = (lock_d == LK_LOCKING);
    if (lock_d == LK_LOCKING) set_start_y_d = SYNC_Y;

    if (lock_d == LK_LOCKING) begin
      req_d = REQ_IDLE;
    end else begin
      case (req_q)
        REQ_IDLE: begin
          if (req_pt_c && (lock_q == LK_LOCKED) && in_rows_c &&
              (ph_y_q == PH_LAST) && !sameLine)
            req_d = REQ_WAIT;
        end
        REQ_WAIT: begin
          if (lineAck) begin
            req_d = REQ_IDLE;
          end else if (line_end_c) begin
            req_d = REQ_IDLE;
            if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
          end
        end
        default: req_d = REQ_IDLE;
      endcase
    end
    line_req_d = (req_d == REQ_WAIT);
  end

  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      lock_q        <= LK_IDLE;
      req_q         <= REQ_IDLE;
      draw_q        <= 1'b0;
      src_x_q       <= '0;
      src_y_q       <= '0;
      ph_x_q        <= '0;
      ph_y_q        <= '0;
      grid_q        <= 1'b0;
      line_req_q    <= 1'b0;
      set_start_q   <= 1'b0;
      set_start_y_q <= '0;
      miss_q        <= '0;
      nf_q          <= 1'b0;
      cy_q          <= '0;
    end else begin
      lock_q        <= lock_d;
      req_q         <= req_d;
      draw_q        <= draw_d;
      src_x_q       <= src_x_d;
      src_y_q       <= src_y_d;
      ph_x_q        <= ph_x_d;
      ph_y_q        <= ph_y_d;
      grid_q        <= grid_d;
      line_req_q    <= line_req_d;
      set_start_q   <= set_start_d;
      set_start_y_q <= set_start_y_d;
      miss_q        <= miss_d;
      nf_q          <= newFrameIn;
      cy_q          <= cy;
    end
  end

  // phaseX delayed to line up with the downstream filter pipeline
  if (PHASE_DELAY == 0) begin : g_no_dly
    assign phaseXDel = ph_x_q;
  end else begin : g_dly
    logic [PH_W-1:0] dly_q [PHASE_DELAY];
    always_ff @(posedge pxlClk or negedge rstN) begin
      if (!rstN) begin
        dly_q <= '{default: '0};
      end else begin
        dly_q[0] <= ph_x_q;
        for (int unsigned i = 1; i < PHASE_DELAY; i++) dly_q[i] <= dly_q[i-1];
      end
    end
    assign phaseXDel = dly_q[PHASE_DELAY-1];
  end

  assign lineReq     = line_req_q;
  assign setStart    = set_start_q;
  assign setStartX   = '0;
  assign setStartY   = set_start_y_q;
  assign drawWin     = draw_q;
  assign srcX        = src_x_q;
  assign srcY        = src_y_q;
  assign phaseX      = ph_x_q;
  assign phaseY      = ph_y_q;
  assign gridAct     = grid_q;
  assign lineMissCnt = miss_q;

endmodule

// File: tb/tb_scale_window_gen.sv
// Scoreboard bench for scale_window_gen: SCALE=4 default instance plus a SCALE=3 instance
// sharing the same HDMI timing inputs.
module tb_scale_window_gen;

  localparam int FW = 1650;
  localparam int FH = 750;

  logic        pxlClk = 1'b0;
  logic        rstN;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic [10:0] fw;
  logic [9:0]  fh;
  logic        nf, same_line, line_ack;

  logic        req4, ss4, draw4, grid4;
  logic [10:0] ssx4;
  logic [9:0]  ssy4;
  logic [7:0]  srcx4, srcy4, miss4;
  logic [1:0]  phx4, phy4, phxd4;

  logic        req3, ss3, draw3, grid3;
  logic [10:0] ssx3;
  logic [9:0]  ssy3;
  logic [7:0]  srcx3, srcy3, miss3;
  logic [1:0]  phx3, phy3, phxd3;

  always #5 pxlClk = ~pxlClk;

  scale_window_gen u_dut (
    .pxlClk(pxlClk), .rstN(rstN), .cx(cx), .cy(cy), .frameWidth(fw), .frameHeight(fh),
    .newFrameIn(nf), .sameLine(same_line), .lineAck(line_ack), .lineReq(req4),
    .setStart(ss4), .setStartX(ssx4), .setStartY(ssy4), .drawWin(draw4), .srcX(srcx4),
    .srcY(srcy4), .phaseX(phx4), .phaseY(phy4), .phaseXDel(phxd4), .gridAct(grid4),
    .lineMissCnt(miss4)
  );

  scale_window_gen #(.SCALE(3)) u_dut3 (
    .pxlClk(pxlClk), .rstN(rstN), .cx(cx), .cy(cy), .frameWidth(fw), .frameHeight(fh),
    .newFrameIn(nf), .sameLine(same_line), .lineAck(line_ack), .lineReq(req3),
    .setStart(ss3), .setStartX(ssx3), .setStartY(ssy3), .drawWin(draw3), .srcX(srcx3),
    .srcY(srcy3), .phaseX(phx3), .phaseY(phy3), .phaseXDel(phxd3), .gridAct(grid3),
    .lineMissCnt(miss3)
  );

  localparam int S_DRAW = 0, S_SRCX = 1, S_PHX = 2, S_SRCY = 3, S_PHY = 4, S_PHXD = 5;
  localparam int S_GRID = 6, S_REQ = 7, S_MISS = 8, S_SS = 9, S_SSX = 10, S_SSY = 11;
  localparam int S3 = 12;  // offset of the SCALE=3 instance's signals
  localparam int N_SIG = 24;

  typedef struct {
    int    due;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  function automatic int get_sig(input int s);
    case (s)
      S_DRAW:      return int'(draw4);
      S_SRCX:      return int'(srcx4);
      S_PHX:       return int'(phx4);
      S_SRCY:      return int'(srcy4);
      S_PHY:       return int'(phy4);
      S_PHXD:      return int'(phxd4);
      S_GRID:      return int'(grid4);
      S_REQ:       return int'(req4);
      S_MISS:      return int'(miss4);
      S_SS:        return int'(ss4);
      S_SSX:       return int'(ssx4);
      S_SSY:       return int'(ssy4);
      S3 + S_DRAW: return int'(draw3);
      S3 + S_SRCX: return int'(srcx3);
      S3 + S_PHX:  return int'(phx3);
      S3 + S_SRCY: return int'(srcy3);
      S3 + S_PHY:  return int'(phy3);
      S3 + S_PHXD: return int'(phxd3);
      S3 + S_GRID: return int'(grid3);
      S3 + S_REQ:  return int'(req3);
      S3 + S_MISS: return int'(miss3);
      S3 + S_SS:   return int'(ss3);
      S3 + S_SSX:  return int'(ssx3);
      S3 + S_SSY:  return int'(ssy3);
      default:     return -1;
    endcase
  endfunction

  function automatic string sig_name(input int s);
    string base[12] = '{"drawWin", "srcX", "phaseX", "srcY", "phaseY", "phaseXDel",
                        "gridAct", "lineReq", "lineMissCnt", "setStart", "setStartX", "setStartY"};
    return (s >= S3) ? {base[s - S3], "(x3)"} : base[s];
  endfunction

  // Expected value of a signal after the next active edge
  function automatic void exp_nxt(input int s, input int v, input string tag);
    exp_t e;
    e.due = cyc + 1; e.sig = s; e.val = v; e.tag = tag;
    sb_q.push_back(e);
  endfunction

  // Expected value at the next sample point without an intervening edge
  function automatic void exp_now(input int s, input int v, input string tag);
    exp_t e;
    e.due = cyc; e.sig = s; e.val = v; e.tag = tag;
    sb_q.push_back(e);
  endfunction

  always @(posedge pxlClk) cyc <= cyc + 1;

  always @(negedge pxlClk) begin : monitor
    exp_t e;
    int   got;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e   = sb_q.pop_front();
      got = get_sig(e.sig);
      n_cmp++;
      if (got != e.val) begin
        n_bad++;
        $display("FAIL %s %s: got %0d want %0d (cycle %0d)", e.tag, sig_name(e.sig), got, e.val, cyc);
      end
    end
  end

  task automatic adv();
    @(negedge pxlClk);
    #1;
  endtask

  task automatic to_phase3();
    repeat (3) begin
      cx = 11'(FW - 1);
      adv();
    end
  endtask

  int win_cx[7]  = '{159, 160, 161, 162, 163, 164, 165};
  int win_dw[7]  = '{0, 1, 1, 1, 1, 1, 1};
  int win_sx[7]  = '{0, 0, 0, 0, 0, 1, 1};
  int win_ph[7]  = '{0, 0, 1, 2, 3, 0, 1};
  int win_pd[7]  = '{0, 0, 0, 0, 1, 2, 3};
  int win_ph3[7] = '{0, 0, 1, 2, 0, 1, 2};
  int win_sx3[7] = '{0, 0, 0, 0, 1, 1, 1};

  initial begin
    rstN = 1'b0; cx = '0; cy = '0; fw = 11'(FW); fh = 10'(FH);
    nf = 1'b0; same_line = 1'b0; line_ack = 1'b0;
    repeat (2) adv();
    for (int s = 0; s < N_SIG; s++) exp_now(s, 0, "reset_init");
    adv();
    rstN = 1'b1;

    // Window entry, SCALE=4 and SCALE=3 side by side
    cy = 10'd40; cx = '0;
    adv();
    for (int i = 0; i < 7; i++) begin
      cx = 11'(win_cx[i]);
      exp_nxt(S_DRAW, win_dw[i], "win_entry");
      exp_nxt(S_SRCX, win_sx[i], "win_entry");
      exp_nxt(S_PHX, win_ph[i], "win_entry");
      exp_nxt(S_PHXD, win_pd[i], "win_entry");
      exp_nxt(S_GRID, 1, "win_entry");
      exp_nxt(S3 + S_DRAW, win_dw[i], "win_entry");
      exp_nxt(S3 + S_PHX, win_ph3[i], "win_entry");
      exp_nxt(S3 + S_SRCX, win_sx3[i], "win_entry");
      adv();
    end
    cx = '0;
    adv();

    // Right edge of the SCALE=3 window
    for (int c = 160; c <= 879; c++) begin
      cx = 11'(c);
      if (c == 879) begin
        exp_nxt(S3 + S_DRAW, 1, "x3_last_col");
        exp_nxt(S3 + S_SRCX, 239, "x3_last_col");
        exp_nxt(S3 + S_PHX, 2, "x3_last_col");
        exp_nxt(S_SRCX, 179, "x4_col879");
        exp_nxt(S_PHX, 3, "x4_col879");
      end
      adv();
    end
    cx = 11'd880;
    exp_nxt(S3 + S_DRAW, 0, "x3_past_end");
    exp_nxt(S3 + S_SRCX, 0, "x3_past_end");
    exp_nxt(S3 + S_PHX, 0, "x3_past_end");
    exp_nxt(S_DRAW, 1, "x4_col880");
    exp_nxt(S_SRCX, 180, "x4_col880");
    exp_nxt(S_PHX, 0, "x4_col880");
    adv();
    cx = '0;
    adv();

    // Vertical phase before lock, then frame lock
    cy = 10'd100; cx = 11'(FW - 1);
    exp_nxt(S_PHY, 1, "phy_pre_lock");
    adv();
    exp_nxt(S_PHY, 2, "phy_pre_lock");
    adv();
    cx = 11'd500;
    exp_nxt(S_PHY, 2, "phy_pre_lock");
    exp_nxt(S_GRID, 1, "phy_pre_lock");
    exp_nxt(S_SS, 0, "idle_no_start");
    adv();
    nf = 1'b1; cx = 11'd501;
    exp_nxt(S_SS, 1, "lock_rise");
    exp_nxt(S_SSY, 38, "lock_rise");
    exp_nxt(S_SSX, 0, "lock_rise");
    adv();
    cx = 11'd502;
    exp_nxt(S_SS, 1, "locking_hold");
    adv();
    cx = 11'(FW - 1);
    exp_nxt(S_PHY, 0, "locking_lineend");
    exp_nxt(S_SRCY, 0, "locking_lineend");
    exp_nxt(S_SS, 1, "locking_lineend");
    adv();
    cy = 10'd38; cx = '0;
    exp_nxt(S_SS, 0, "locked");
    exp_nxt(S_SSY, 38, "locked");
    adv();
    cx = 11'd1;
    exp_nxt(S_SS, 0, "locked_hold");
    adv();

    // Line request acknowledged
    cy = 10'd100; cx = 11'(FW - 1);
    exp_nxt(S_PHY, 1, "phy_locked");
    adv();
    cx = 11'd160;
    exp_nxt(S_GRID, 1, "grid_phx0");
    adv();
    cx = 11'd161;
    exp_nxt(S_GRID, 0, "grid_inner");
    adv();
    cx = 11'(FW - 1);
    adv();
    adv();
    same_line = 1'b1; cx = 11'(FW - 8);
    exp_nxt(S_PHY, 3, "req_sameline");
    exp_nxt(S_REQ, 0, "req_sameline");
    adv();
    same_line = 1'b0; cx = 11'(FW - 8);
    exp_nxt(S_REQ, 1, "req_raise");
    adv();
    cx = 11'(FW - 7);
    exp_nxt(S_REQ, 1, "req_wait");
    adv();
    cx = 11'(FW - 6);
    exp_nxt(S_REQ, 1, "req_wait");
    adv();
    cx = 11'(FW - 5); line_ack = 1'b1;
    exp_nxt(S_REQ, 0, "req_ack");
    adv();
    cx = 11'(FW - 4);
    exp_nxt(S_REQ, 0, "ack_in_idle");
    adv();
    line_ack = 1'b0; cx = 11'(FW - 1);
    exp_nxt(S_REQ, 0, "ack_lineend");
    exp_nxt(S_MISS, 0, "ack_lineend");
    exp_nxt(S_PHY, 0, "ack_lineend");
    exp_nxt(S_SRCY, 1, "ack_lineend");
    adv();

    // Unacknowledged request
    to_phase3();
    cx = 11'(FW - 8);
    exp_nxt(S_REQ, 1, "miss_raise");
    adv();
    cx = 11'(FW - 2);
    exp_nxt(S_REQ, 1, "miss_wait");
    adv();
    cx = 11'(FW - 1);
    exp_nxt(S_REQ, 0, "miss_drop");
    exp_nxt(S_MISS, 1, "miss_drop");
    exp_nxt(S_SRCY, 2, "miss_drop");
    adv();

    // Ack on the line-end cycle wins over a miss
    to_phase3();
    cx = 11'(FW - 8);
    exp_nxt(S_REQ, 1, "ack_at_end_raise");
    adv();
    cx = 11'(FW - 1); line_ack = 1'b1;
    exp_nxt(S_REQ, 0, "ack_at_end");
    exp_nxt(S_MISS, 1, "ack_at_end");
    exp_nxt(S_SRCY, 3, "ack_at_end");
    adv();
    line_ack = 1'b0;

    // Miss counter and srcY saturation
    for (int i = 0; i < 299; i++) begin
      to_phase3();
      cx = 11'(FW - 8);
      adv();
      cx = 11'(FW - 1);
      if (i == 252) exp_nxt(S_MISS, 254, "miss_254");
      if (i == 298) begin
        exp_nxt(S_MISS, 255, "miss_sat");
        exp_nxt(S_SRCY, 159, "srcy_sat");
        exp_nxt(S_REQ, 0, "miss_sat");
      end
      adv();
    end

    // Asynchronous reset with a request outstanding
    to_phase3();
    cx = 11'(FW - 8);
    exp_nxt(S_REQ, 1, "pre_reset_req");
    exp_nxt(S_SSY, 38, "pre_reset_req");
    adv();
    nf = 1'b0;
    @(posedge pxlClk);
    #1;
    rstN = 1'b0;
    for (int s = 0; s < S3; s++) exp_now(s, 0, "reset_midreq");
    adv();
    rstN = 1'b1; cx = '0; cy = '0;
    exp_nxt(S_MISS, 0, "post_reset");
    exp_nxt(S_SS, 0, "post_reset");
    exp_nxt(S_REQ, 0, "post_reset");
    adv();
    adv();

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
